// File: rtl/pipe_ctrl_carrier_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_carrier_if
// Bundle between the ID-stage control unit / datapath muxes and the pipeline
// control carrier.
//   master : control unit + datapath side (drives the ID bundles and alu_zero,
//            receives the per-stage controls, hazard and forwarding selects)
//   slave  : pipe_ctrl_carrier
// Signals:
//   EX[ALUOP_W+1:0] {RegDst,ALUOp,ALUSrc}   MEM[2:0] {MemRead,MemWrite,MemtoReg}
//   WB[1:0] {RegWrite,MemtoReg}   Jump, JR   id_rs/id_rt/id_rd   alu_zero
//   ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite, mem_pcsrc,
//   wb_RegWrite, wb_MemtoReg, wb_dst, stall, flush_ifid, fwd_a, fwd_b
// -----------------------------------------------------------------------------
interface pipe_ctrl_carrier_if #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
);
  logic [ALUOP_W+1:0] EX;
  logic [2:0]         MEM;
  logic [1:0]         WB;
  logic               Jump;
  logic               JR;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [REG_W-1:0]   id_rd;
  logic               alu_zero;

  logic               ex_RegDst;
  logic               ex_ALUSrc;
  logic [ALUOP_W-1:0] ex_ALUOp;
  logic               mem_MemRead;
  logic               mem_MemWrite;
  logic               mem_pcsrc;
  logic               wb_RegWrite;
  logic               wb_MemtoReg;
  logic [REG_W-1:0]   wb_dst;
  logic               stall;
  logic               flush_ifid;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;

  modport master (
    output EX, MEM, WB, Jump, JR, id_rs, id_rt, id_rd, alu_zero,
    input  ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite, mem_pcsrc,
           wb_RegWrite, wb_MemtoReg, wb_dst, stall, flush_ifid, fwd_a, fwd_b
  );

  modport slave (
    input  EX, MEM, WB, Jump, JR, id_rs, id_rt, id_rd, alu_zero,
    output ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite, mem_pcsrc,
           wb_RegWrite, wb_MemtoReg, wb_dst, stall, flush_ifid, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_ctrl_carrier.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_carrier
// Carries the control-unit bundles through the ID/EX, EX/MEM and MEM/WB stage
// registers of a 5-stage MIPS pipeline, decodes them per stage, and owns hazard
// handling (load-use stall, branch/jump flush, operand forwarding selects).
// Ports:
//   clk    pipeline clock, all state on the rising edge
//   rst_n  synchronous active-low reset
//   bus    pipe_ctrl_carrier_if.slave (ID bundles in, stage controls out)
// Build option:
//   FORWARDING_EN  defined   : EX/MEM and MEM/WB forwarding, load-use stalls only
//                  undefined : fwd_a/fwd_b tied to 00, stall on any RAW dependency
//                              against the producers in ID/EX or EX/MEM
// JR is folded into Jump by the control unit, and MEM[0] duplicates WB[0]; both
// are accepted for bundle completeness but not needed here.
// -----------------------------------------------------------------------------
module pipe_ctrl_carrier #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_ctrl_carrier_if.slave   bus
);

  typedef struct packed {
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               memto_reg;
    logic               branch;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
  } id_ex_t;

  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             memto_reg;
    logic             branch;
    logic             zero;
    logic [REG_W-1:0] dst;
  } ex_mem_t;

  typedef struct packed {
    logic             reg_write;
    logic             memto_reg;
    logic [REG_W-1:0] dst;
  } mem_wb_t;

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  // ID-stage decode of the EX bundle
  logic               id_reg_dst;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               id_alu_src;
  logic               id_branch;
  assign {id_reg_dst, id_alu_op, id_alu_src} = bus.EX;

  // Jumps resolve in ID, so a jump must never also launch a branch.
  assign id_branch = (id_alu_op == ALUOP_W'(1)) & ~id_alu_src & ~bus.Jump;

  logic [REG_W-1:0] ex_dst;
  assign ex_dst = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;

  // True when nonzero register r is read by either ID source field.
  function automatic logic reads(input logic [REG_W-1:0] r,
                                 input logic [REG_W-1:0] rs,
                                 input logic [REG_W-1:0] rt);
    return (r != '0) && ((r == rs) || (r == rt));
  endfunction

  logic mem_pcsrc;
  logic load_use;
  logic raw_hazard;
  logic stall;
  assign mem_pcsrc = ex_mem_q.branch & ex_mem_q.zero;
  assign load_use  = id_ex_q.mem_read & reads(id_ex_q.rt, bus.id_rs, bus.id_rt);

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input ex_mem_t em, input mem_wb_t mw);
    if (em.reg_write && (em.dst != '0) && (em.dst == src)) return 2'b10;
    if (mw.reg_write && (mw.dst != '0) && (mw.dst == src)) return 2'b01;
    return 2'b00;
  endfunction

  assign raw_hazard = load_use;
  assign bus.fwd_a  = fwd_sel(id_ex_q.rs, ex_mem_q, mem_wb_q);
  assign bus.fwd_b  = fwd_sel(id_ex_q.rt, ex_mem_q, mem_wb_q);

  logic unused_bits;
  assign unused_bits = ^{bus.JR, bus.MEM[0]};
`else
  // Without forwarding every in-flight producer ahead of WB blocks ID; the
  // register file's write-then-read covers the MEM/WB case.
  assign raw_hazard = load_use
                    | (id_ex_q.reg_write  & reads(ex_dst,       bus.id_rs, bus.id_rt))
                    | (ex_mem_q.reg_write & reads(ex_mem_q.dst, bus.id_rs, bus.id_rt));
  assign bus.fwd_a  = 2'b00;
  assign bus.fwd_b  = 2'b00;

  logic unused_bits;
  assign unused_bits = ^{bus.JR, bus.MEM[0], id_ex_q.rs};
`endif

  // A taken branch squashes everything younger, including whatever stalled.
  assign stall          = raw_hazard & ~mem_pcsrc;
  assign bus.stall      = stall;
  assign bus.flush_ifid = mem_pcsrc | (bus.Jump & ~stall);
  assign bus.mem_pcsrc  = mem_pcsrc;

  // NOTE: every variable written in always_comb gets its full value first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    id_ex_d  = '{reg_dst:   id_reg_dst,    alu_op:    id_alu_op,
                 alu_src:   id_alu_src,    mem_read:  bus.MEM[2],
                 mem_write: bus.MEM[1],    reg_write: bus.WB[1],
                 memto_reg: bus.WB[0],     branch:    id_branch,
                 rs:        bus.id_rs,     rt:        bus.id_rt,
                 rd:        bus.id_rd};
    ex_mem_d = '{mem_read:  id_ex_q.mem_read,  mem_write: id_ex_q.mem_write,
                 reg_write: id_ex_q.reg_write, memto_reg: id_ex_q.memto_reg,
                 branch:    id_ex_q.branch,    zero:      bus.alu_zero,
                 dst:       ex_dst};
    mem_wb_d = '{reg_write: ex_mem_q.reg_write, memto_reg: ex_mem_q.memto_reg,
                 dst:       ex_mem_q.dst};
    if (mem_pcsrc) begin
      id_ex_d  = '0;
      ex_mem_d = '0;
    end else if (stall) begin
      id_ex_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of the stage ahead of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus.ex_RegDst    = id_ex_q.reg_dst;
  assign bus.ex_ALUSrc    = id_ex_q.alu_src;
  assign bus.ex_ALUOp     = id_ex_q.alu_op;
  assign bus.mem_MemRead  = ex_mem_q.mem_read;
  assign bus.mem_MemWrite = ex_mem_q.mem_write;
  assign bus.wb_RegWrite  = mem_wb_q.reg_write;
  assign bus.wb_MemtoReg  = mem_wb_q.memto_reg;
  assign bus.wb_dst       = mem_wb_q.dst;

endmodule

// File: tb/tb_pipe_ctrl_carrier.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_carrier
// Directed bench for pipe_ctrl_carrier: a vector table of single-cycle
// {inputs, expected outputs} records covering reset, stage latency, branch
// flush and jump, plus hand-written multi-cycle sequences for forwarding,
// load-use and stall/flush interaction. Expectations follow FORWARDING_EN.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_carrier;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 2;

  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic       jump;
    logic       jr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  // Observed outputs, packed in a fixed order for whole-vector comparison.
  typedef struct packed {
    logic       ex_rd;
    logic       ex_as;
    logic [1:0] ex_op;
    logic       mr;
    logic       mw;
    logic       pc;
    logic       rw;
    logic       mtr;
    logic [4:0] dst;
    logic       st;
    logic       fl;
    logic [1:0] fa;
    logic [1:0] fb;
  } out_t;

  typedef struct {
    string  name;
    logic   rst;
    instr_t in;
    logic   zero;
    out_t   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  pipe_ctrl_carrier_if #(.REG_W(REG_W), .ALUOP_W(ALUOP_W)) bus ();

  pipe_ctrl_carrier #(.REG_W(REG_W), .ALUOP_W(ALUOP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  out_t act;
  assign act = {bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_ALUOp, bus.mem_MemRead,
                bus.mem_MemWrite, bus.mem_pcsrc, bus.wb_RegWrite, bus.wb_MemtoReg,
                bus.wb_dst, bus.stall, bus.flush_ifid, bus.fwd_a, bus.fwd_b};

  localparam instr_t NOP = '0;

  function automatic instr_t r_type(input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rt);
    return '{ex: 4'b1100, mem: 3'b000, wb: 2'b10, jump: 1'b0, jr: 1'b0,
             rs: rs, rt: rt, rd: rd};
  endfunction

  function automatic instr_t lw(input logic [4:0] rt, input logic [4:0] rs);
    return '{ex: 4'b0001, mem: 3'b101, wb: 2'b11, jump: 1'b0, jr: 1'b0,
             rs: rs, rt: rt, rd: 5'd0};
  endfunction

  function automatic instr_t beq(input logic [4:0] rs, input logic [4:0] rt);
    return '{ex: 4'b0010, mem: 3'b000, wb: 2'b00, jump: 1'b0, jr: 1'b0,
             rs: rs, rt: rt, rd: 5'd0};
  endfunction

  function automatic instr_t j_instr();
    return '{ex: 4'b0010, mem: 3'b000, wb: 2'b00, jump: 1'b1, jr: 1'b0,
             rs: 5'd0, rt: 5'd0, rd: 5'd0};
  endfunction

  function automatic instr_t jr_instr(input logic [4:0] rs);
    return '{ex: 4'b0000, mem: 3'b000, wb: 2'b00, jump: 1'b1, jr: 1'b1,
             rs: rs, rt: 5'd0, rd: 5'd0};
  endfunction

  task automatic apply(input logic rst, input instr_t i, input logic zero);
    rst_n        = rst;
    bus.EX       = i.ex;
    bus.MEM      = i.mem;
    bus.WB       = i.wb;
    bus.Jump     = i.jump;
    bus.JR       = i.jr;
    bus.id_rs    = i.rs;
    bus.id_rt    = i.rt;
    bus.id_rd    = i.rd;
    bus.alu_zero = zero;
  endtask

  // One pipeline cycle: drive just after the edge, settle to the falling edge.
  task automatic cyc(input instr_t i, input logic zero);
    @(posedge clk);
    #1;
    apply(1'b1, i, zero);
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) cyc(NOP, 1'b0);
  endtask

  task automatic check(input string name, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic rst, input instr_t in,
                         input logic zero, input out_t exp);
    vec_t v;
    v.name = name; v.rst = rst; v.in = in; v.zero = zero; v.exp = exp;
    vt.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, stage latency, branch flush and jump: same in both builds.
    add_vec("rst0",    1'b0, lw(5'd2, 5'd1), 1'b0, '0);
    add_vec("rst1",    1'b0, lw(5'd2, 5'd1), 1'b0, '0);
    add_vec("release", 1'b1, lw(5'd2, 5'd1), 1'b0, '0);
    add_vec("lw_ex",   1'b1, NOP, 1'b0, out_t'{ex_as: 1'b1, default: '0});
    add_vec("lw_mem",  1'b1, NOP, 1'b0, out_t'{mr: 1'b1, default: '0});
    add_vec("lw_wb",   1'b1, r_type(5'd7, 5'd8, 5'd9), 1'b0,
            out_t'{rw: 1'b1, mtr: 1'b1, dst: 5'd2, default: '0});
    add_vec("r_ex",    1'b1, NOP, 1'b0, out_t'{ex_rd: 1'b1, ex_op: 2'b10, default: '0});
    add_vec("r_mem",   1'b1, NOP, 1'b0, '0);
    add_vec("r_wb",    1'b1, beq(5'd5, 5'd0), 1'b0,
            out_t'{rw: 1'b1, dst: 5'd7, default: '0});
    add_vec("beq_ex",  1'b1, r_type(5'd10, 5'd11, 5'd12), 1'b1,
            out_t'{ex_op: 2'b01, default: '0});
    add_vec("beq_mem", 1'b1, r_type(5'd13, 5'd14, 5'd15), 1'b0,
            out_t'{ex_rd: 1'b1, ex_op: 2'b10, pc: 1'b1, fl: 1'b1, default: '0});
    add_vec("flush1",  1'b1, NOP, 1'b0, '0);
    add_vec("flush2",  1'b1, NOP, 1'b0, '0);
    add_vec("flush3",  1'b1, NOP, 1'b0, '0);
    add_vec("j_id",    1'b1, j_instr(), 1'b1, out_t'{fl: 1'b1, default: '0});
    add_vec("j_ex",    1'b1, NOP, 1'b1, out_t'{ex_op: 2'b01, default: '0});
    add_vec("j_mem",   1'b1, NOP, 1'b0, '0);

    foreach (vt[k]) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      apply(vt[k].rst, vt[k].in, vt[k].zero);
      @(negedge clk);
      check(vt[k].name, vt[k].exp);
    end

`ifdef FORWARDING_EN
    // add $3 then sub $4,$3,$5: EX/MEM forward on rs
    drain();
    cyc(r_type(5'd3, 5'd1, 5'd2), 1'b0); check("fx_c1", '0);
    cyc(r_type(5'd4, 5'd3, 5'd5), 1'b0);
    check("fx_c2", out_t'{ex_rd: 1'b1, ex_op: 2'b10, default: '0});
    cyc(NOP, 1'b0);
    check("fx_fwd", out_t'{ex_rd: 1'b1, ex_op: 2'b10, fa: 2'b10, default: '0});

    // one nop between: MEM/WB forward
    drain();
    cyc(r_type(5'd3, 5'd1, 5'd2), 1'b0); check("fw_c1", '0);
    cyc(NOP, 1'b0);
    check("fw_c2", out_t'{ex_rd: 1'b1, ex_op: 2'b10, default: '0});
    cyc(r_type(5'd4, 5'd3, 5'd5), 1'b0); check("fw_c3", '0);
    cyc(NOP, 1'b0);
    check("fw_fwd", out_t'{ex_rd: 1'b1, ex_op: 2'b10, rw: 1'b1, dst: 5'd3,
                           fa: 2'b01, default: '0});

    // both stages write $3: EX/MEM wins on both operands
    drain();
    cyc(r_type(5'd3, 5'd1, 5'd2), 1'b0);
    cyc(r_type(5'd3, 5'd6, 5'd7), 1'b0);
    cyc(r_type(5'd4, 5'd3, 5'd3), 1'b0);
    check("fb_c3", out_t'{ex_rd: 1'b1, ex_op: 2'b10, default: '0});
    cyc(NOP, 1'b0);
    check("fb_fwd", out_t'{ex_rd: 1'b1, ex_op: 2'b10, rw: 1'b1, dst: 5'd3,
                           fa: 2'b10, fb: 2'b10, default: '0});

    // writes to $0 are never forwarded
    drain();
    cyc(r_type(5'd0, 5'd1, 5'd2), 1'b0);
    cyc(r_type(5'd4, 5'd0, 5'd0), 1'b0);
    cyc(NOP, 1'b0);
    check("r0_fwd", out_t'{ex_rd: 1'b1, ex_op: 2'b10, default: '0});
`else
    // add $3 then add $6,$3,$3: two stall cycles, no forwarding
    drain();
    cyc(r_type(5'd3, 5'd1, 5'd2), 1'b0); check("nf_c1", '0);
    cyc(r_type(5'd6, 5'd3, 5'd3), 1'b0);
    check("nf_st1", out_t'{ex_rd: 1'b1, ex_op: 2'b10, st: 1'b1, default: '0});
    cyc(r_type(5'd6, 5'd3, 5'd3), 1'b0);
    check("nf_st2", out_t'{st: 1'b1, default: '0});
    cyc(r_type(5'd6, 5'd3, 5'd3), 1'b0);
    check("nf_rel", out_t'{rw: 1'b1, dst: 5'd3, default: '0});
    cyc(NOP, 1'b0);
    check("nf_ex", out_t'{ex_rd: 1'b1, ex_op: 2'b10, default: '0});
`endif

    // lw $2,0($1) then add $3,$4,$2
    drain();
    cyc(lw(5'd2, 5'd1), 1'b0); check("lu_c1", '0);
    cyc(r_type(5'd3, 5'd4, 5'd2), 1'b0);
    check("lu_stall", out_t'{ex_as: 1'b1, st: 1'b1, default: '0});
`ifdef FORWARDING_EN
    cyc(r_type(5'd3, 5'd4, 5'd2), 1'b0);
    check("lu_bubble", out_t'{mr: 1'b1, default: '0});
    cyc(NOP, 1'b0);
    check("lu_fwd", out_t'{ex_rd: 1'b1, ex_op: 2'b10, rw: 1'b1, mtr: 1'b1,
                           dst: 5'd2, fb: 2'b01, default: '0});
`else
    cyc(r_type(5'd3, 5'd4, 5'd2), 1'b0);
    check("lu_bubble", out_t'{mr: 1'b1, st: 1'b1, default: '0});
    cyc(r_type(5'd3, 5'd4, 5'd2), 1'b0);
    check("lu_rel", out_t'{rw: 1'b1, mtr: 1'b1, dst: 5'd2, default: '0});
    cyc(NOP, 1'b0);
    check("lu_ex", out_t'{ex_rd: 1'b1, ex_op: 2'b10, default: '0});
`endif

    // lw $2 then jr $2: the jump flushes only once the stall releases
    drain();
    cyc(lw(5'd2, 5'd1), 1'b0);
    cyc(jr_instr(5'd2), 1'b0);
    check("jr_held", out_t'{ex_as: 1'b1, st: 1'b1, default: '0});
`ifdef FORWARDING_EN
    cyc(jr_instr(5'd2), 1'b0);
    check("jr_flush", out_t'{mr: 1'b1, fl: 1'b1, default: '0});
`else
    cyc(jr_instr(5'd2), 1'b0);
    check("jr_held2", out_t'{mr: 1'b1, st: 1'b1, default: '0});
    cyc(jr_instr(5'd2), 1'b0);
    check("jr_flush", out_t'{rw: 1'b1, mtr: 1'b1, dst: 5'd2, fl: 1'b1, default: '0});
`endif

    // taken beq in MEM while a load-use is pending: flush wins, lw squashed
    drain();
    cyc(beq(5'd5, 5'd0), 1'b0);
    cyc(lw(5'd2, 5'd1), 1'b1);
    check("bs_ex", out_t'{ex_op: 2'b01, default: '0});
    cyc(r_type(5'd3, 5'd4, 5'd2), 1'b0);
    check("bs_flush", out_t'{ex_as: 1'b1, pc: 1'b1, fl: 1'b1, default: '0});
    cyc(NOP, 1'b0);
    check("bs_bubble", '0);

    // lw $0 never causes a load-use stall
    drain();
    cyc(lw(5'd0, 5'd1), 1'b0);
    cyc(r_type(5'd3, 5'd0, 5'd0), 1'b0);
    check("lu_r0", out_t'{ex_as: 1'b1, default: '0});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
